// File: rtl/cla_nibble_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cla_nibble_seq_ctrl
//
// Purpose:
//   Performs a WIDTH-bit add or subtract by time-multiplexing a single external
//   4-bit carry-lookahead adder slice. One nibble is processed per clock, least
//   significant nibble first, and the carry between nibbles is held in a
//   register. Subtraction is done as A + ~B + 1: B is inverted when it is
//   latched and the initial carry is forced to 1.
//
//   Operation is a three-state sequence:
//     IDLE : ready for an operand pair (in_ready=1)
//     RUN  : NIB cycles, one nibble per cycle through the external slice
//     DONE : result presented (out_valid=1) until the sink accepts it
//
// Parameters:
//   WIDTH        operand/result width; multiple of 4 and >= 8 (NIB = WIDTH/4)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   in_valid     operand request valid
//   in_ready     controller can accept an operand request (IDLE only)
//   op_a, op_b   operands
//   op_cin       carry-in for add; ignored when op_sub=1
//   op_sub       1: A - B, 0: A + B + op_cin
//   out_valid    result valid (DONE only)
//   out_ready    sink accepts result
//   result       sum / difference
//   result_cout  carry out of the MSB nibble (for subtract: 1 = no borrow)
//   result_ovf   two's-complement signed overflow
//   add_a        A nibble to the external CLA slice
//   add_b        effective-B nibble to the external CLA slice
//   add_cin      carry into the external CLA slice
//   add_sum      slice sum, combinational from add_a/add_b/add_cin
//   add_cout     slice carry out, combinational from add_a/add_b/add_cin
// -----------------------------------------------------------------------------
module cla_nibble_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    input  logic             op_sub,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_cout,
    output logic             result_ovf,

    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;          // already inverted for subtract
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               result_cout_q, result_cout_d;
    logic               result_ovf_q, result_ovf_d;

    logic               accept;
    logic               last_nib;
    logic [3:0]         a_nib [NIB];
    logic [3:0]         b_nib [NIB];

    // Split the latched operands into nibble arrays so the active nibble can
    // be picked with a plain index instead of a variable part-select.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nib[gi] = a_q[4*gi +: 4];
            assign b_nib[gi] = b_q[4*gi +: 4];
        end
    endgenerate

    assign accept   = (state_q == ST_IDLE) && in_valid;
    assign last_nib = (idx_q == LAST_IDX);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            carry_q       <= 1'b0;
            idx_q         <= '0;
            result_q      <= '0;
            result_cout_q <= 1'b0;
            result_ovf_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            carry_q       <= carry_d;
            idx_q         <= idx_d;
            result_q      <= result_d;
            result_cout_q <= result_cout_d;
            result_ovf_q  <= result_ovf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_nib) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        a_d           = a_q;
        b_d           = b_q;
        carry_d       = carry_q;
        idx_d         = idx_q;
        result_d      = result_q;
        result_cout_d = result_cout_q;
        result_ovf_d  = result_ovf_q;

        if (accept) begin
            a_d     = op_a;
            b_d     = op_sub ? ~op_b : op_b;
            carry_d = op_sub ? 1'b1 : op_cin;
            idx_d   = '0;
        end else if (state_q == ST_RUN) begin
            // Result nibbles from earlier operations are simply overwritten
            // one by one; the previous result stays readable until then.
            result_d[{idx_q, 2'b00} +: 4] = add_sum;
            carry_d                       = add_cout;
            if (last_nib) begin
                idx_d         = '0;
                result_cout_d = add_cout;
                // Signed overflow: both addends share a sign that the MSB
                // of the sum does not. b_q is the effective (inverted) B.
                result_ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                (add_sum[3] != a_q[WIDTH-1]);
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = 4'd0;
        add_b     = 4'd0;
        add_cin   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_RUN: begin
                add_a   = a_nib[idx_q];
                add_b   = b_nib[idx_q];
                add_cin = carry_q;
            end
            ST_DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign result      = result_q;
    assign result_cout = result_cout_q;
    assign result_ovf  = result_ovf_q;

endmodule

// File: tb/tb_cla_nibble_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for cla_nibble_seq_ctrl (WIDTH=16).
// Provides the external 4-bit adder slice behaviourally, runs directed and
// randomized operations and compares against a plain-arithmetic model.
// -----------------------------------------------------------------------------
module tb_cla_nibble_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             result_cout;
    logic             result_ovf;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // External 4-bit adder slice
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    cla_nibble_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_cin      (op_cin),
        .op_sub      (op_sub),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_cout (result_cout),
        .result_ovf  (result_ovf),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_cin     (add_cin),
        .add_sum     (add_sum),
        .add_cout    (add_cout)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the whole words.
    function automatic void ref_model(input logic [15:0] a, input logic [15:0] b,
                                      input logic cin, input logic sub,
                                      output logic [15:0] r, output logic co,
                                      output logic ov);
        int          sa;
        int          sb;
        int          s;
        logic [16:0] u;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            r  = a - b;
            co = (a >= b);
            s  = sa - sb;
        end else begin
            u  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            r  = u[15:0];
            co = u[16];
            s  = sa + sb + int'(cin);
        end
        ov = (s > 32767) || (s < -32768);
    endfunction

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // One full transaction: accept, NIB RUN cycles, DONE held for 'hold'
    // cycles with out_ready low and in_valid high, then handshake.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          input logic [15:0] exp_r, input logic exp_co,
                          input logic exp_ov, input int hold);
        logic [15:0] effb;
        logic        c0;
        logic [31:0] mask;
        logic [31:0] part;

        effb = sub ? ~b : b;
        c0   = sub ? 1'b1 : cin;

        check_val("idle_in_ready", 32'(in_ready), 32'd1);
        check_val("idle_out_valid", 32'(out_valid), 32'd0);
        check_val("idle_add_a", 32'(add_a), 32'd0);

        op_a = a; op_b = b; op_cin = cin; op_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < NIB; k++) begin
            // Anything on the request side must be ignored while running;
            // out_ready before out_valid must also have no effect.
            in_valid  = 1'($urandom_range(0, 1));
            op_a      = 16'($urandom);
            op_b      = 16'($urandom);
            op_cin    = 1'($urandom_range(0, 1));
            op_sub    = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            mask = (32'd1 << (4 * k)) - 32'd1;
            part = (({16'd0, a} & mask) + ({16'd0, effb} & mask) + {31'd0, c0}) >> (4 * k);
            check_val("run_add_a", 32'(add_a), 32'(a[4*k +: 4]));
            check_val("run_add_b", 32'(add_b), 32'(effb[4*k +: 4]));
            check_val("run_add_cin", 32'(add_cin), {31'd0, part[0]});
            check_val("run_out_valid", 32'(out_valid), 32'd0);
            check_val("run_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end

        check_val("done_out_valid", 32'(out_valid), 32'd1);
        check_val("done_result", 32'(result), 32'(exp_r));
        check_val("done_cout", 32'(result_cout), 32'(exp_co));
        check_val("done_ovf", 32'(result_ovf), 32'(exp_ov));
        check_val("done_in_ready", 32'(in_ready), 32'd0);

        in_valid = 1'b1;
        op_a     = 16'($urandom);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
            check_val("hold_out_valid", 32'(out_valid), 32'd1);
            check_val("hold_in_ready", 32'(in_ready), 32'd0);
            check_val("hold_result", 32'(result), 32'(exp_r));
            check_val("hold_add_a", 32'(add_a), 32'd0);
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_val("hs_out_valid", 32'(out_valid), 32'd0);
        check_val("hs_in_ready", 32'(in_ready), 32'd1);
        check_val("hs_result_kept", 32'(result), 32'(exp_r));
        check_val("hs_cout_kept", 32'(result_cout), 32'(exp_co));

        $display("op %s a=0x%04h b=0x%04h cin=%0d -> result=0x%04h cout=%0d ovf=%0d hold=%0d",
                 sub ? "sub" : "add", a, b, cin, result, result_cout, result_ovf, hold);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rcin;
        logic        rsub;
        logic [15:0] er;
        logic        eco;
        logic        eov;

        rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0;
        op_cin = 1'b0; op_sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_result", 32'(result), 32'd0);
        check_val("rst_cout", 32'(result_cout), 32'd0);
        check_val("rst_ovf", 32'(result_ovf), 32'd0);
        check_val("rst_add_b", 32'(add_b), 32'd0);
        check_val("rst_add_cin", 32'(add_cin), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases with hand-computed expectations
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 2);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
        // Long back-pressure with a pending request, then a second op
        run_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 10);
        run_op(16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0, 0);

        // Reset during the second RUN cycle aborts the operation
        op_a = 16'hABCD; op_b = 16'h1357; op_cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("abort_in_ready", 32'(in_ready), 32'd1);
        check_val("abort_out_valid", 32'(out_valid), 32'd0);
        check_val("abort_result", 32'(result), 32'd0);
        check_val("abort_cout", 32'(result_cout), 32'd0);
        check_val("abort_ovf", 32'(result_ovf), 32'd0);
        for (int i = 0; i < NIB + 2; i++) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            check_val("abort_no_output", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        $display("op abort: reset during RUN, no result produced");

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            ra   = pick_operand();
            rb   = pick_operand();
            rcin = 1'($urandom_range(0, 1));
            rsub = 1'($urandom_range(0, 1));
            ref_model(ra, rb, rcin, rsub, er, eco, eov);
            run_op(ra, rb, rcin, rsub, er, eco, eov, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
